// File: rtl/pc_branch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_branch_sequencer
//
// Multi-cycle program-counter sequencer for a CBZ / CBNZ / B capable core.
// Each instruction walks FETCH -> EXEC -> UPDATE. After reset a single IDLE
// cycle precedes the first FETCH.
//
// Handshakes (one rule for both): a transfer happens on the rising clock
// edge where the sequencer is in the waiting state and the partner's flag is
// high. In FETCH, fetch_req is the valid and imem_ready is the ready. In
// EXEC, exec_valid marks Zero/branch controls/SEout as valid and the
// sequencer is always ready. A flag seen outside its own state is ignored.
//
// Ports
//   clock          system clock, all state moves on the rising edge
//   reset          asynchronous, active-high
//   Branch         CBZ  : taken when Zero = 1
//   BranchNZ       CBNZ : taken when Zero = 0
//   UncondBranch   B    : always taken
//   Zero           ALU zero flag, valid with exec_valid
//   SEout[63:0]    sign-extended word offset of the branch
//   exec_valid     RF/ALU result valid this cycle
//   imem_ready     instruction memory accepted the fetch at PC
//   PC[63:0]       current program counter
//   fetch_req      instruction request at PC (FETCH only)
//   branch_taken   one-cycle pulse in UPDATE when a taken branch commits
//   instr_count    retired-instruction counter, wraps at 2^32
//   state_dbg[1:0] current FSM state for observation
// ---------------------------------------------------------------------------
module pc_branch_sequencer #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Branch,
    input  logic        BranchNZ,
    input  logic        UncondBranch,
    input  logic        Zero,
    input  logic [63:0] SEout,
    input  logic        exec_valid,
    input  logic        imem_ready,
    output logic [63:0] PC,
    output logic        fetch_req,
    output logic        branch_taken,
    output logic [31:0] instr_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [63:0] target_q, target_d;
    logic        taken_q, taken_d;
    logic [31:0] instr_count_q, instr_count_d;
    logic        taken_now;

    // Several controls may be asserted at once; they simply OR together.
    assign taken_now = UncondBranch | (Branch & Zero) | (BranchNZ & ~Zero);

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        target_d      = target_q;
        taken_d       = taken_q;
        instr_count_d = instr_count_q;
        fetch_req     = 1'b0;
        branch_taken  = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (imem_ready) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (exec_valid) begin
                    taken_d  = taken_now;
                    // Word offset to byte offset; wraps modulo 2^64, so a
                    // negative SEout gives a backward target.
                    target_d = pc_q + (SEout << 2);
                    state_d  = UPDATE;
                end
            end
            UPDATE: begin
                branch_taken  = taken_q;
                pc_d          = taken_q ? target_q : pc_q + 64'd4;
                instr_count_d = instr_count_q + 32'd1;
                taken_d       = 1'b0;
                state_d       = FETCH;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from state, so the async reset clears fetch_req
    // and branch_taken immediately along with the state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            target_q      <= 64'd0;
            taken_q       <= 1'b0;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
            taken_q       <= taken_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign PC          = pc_q;
    assign instr_count = instr_count_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_sequencer
//
// Two instances: dut1 with RESET_PC = 0 and dut2 with RESET_PC near the top
// of the address space (for the PC wrap case). Both share the control
// inputs; `sel` picks whose outputs are checked. A directed table covers
// the named cases, hand-written sequences cover async reset in EXEC and
// UPDATE plus the counter wrap, and a random phase is checked against an
// instruction-level model (taken rule + address arithmetic).
// ---------------------------------------------------------------------------
module tb_pc_branch_sequencer;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        Branch = 1'b0, BranchNZ = 1'b0, UncondBranch = 1'b0, Zero = 1'b0;
    logic [63:0] SEout = 64'd0;
    logic        exec_valid = 1'b0, imem_ready = 1'b0;

    logic [63:0] pc1, pc2, pc_m;
    logic        fr1, fr2, fr_m, bt1, bt2, bt_m;
    logic [31:0] cnt1, cnt2, cnt_m;
    logic [1:0]  st1, st2;
    logic        sel = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    always #5 clock = ~clock;

    pc_branch_sequencer #(.RESET_PC(64'h0)) dut1 (
        .clock(clock), .reset(reset), .Branch(Branch), .BranchNZ(BranchNZ),
        .UncondBranch(UncondBranch), .Zero(Zero), .SEout(SEout),
        .exec_valid(exec_valid), .imem_ready(imem_ready),
        .PC(pc1), .fetch_req(fr1), .branch_taken(bt1), .instr_count(cnt1),
        .state_dbg(st1)
    );

    pc_branch_sequencer #(.RESET_PC(WRAP_PC)) dut2 (
        .clock(clock), .reset(reset), .Branch(Branch), .BranchNZ(BranchNZ),
        .UncondBranch(UncondBranch), .Zero(Zero), .SEout(SEout),
        .exec_valid(exec_valid), .imem_ready(imem_ready),
        .PC(pc2), .fetch_req(fr2), .branch_taken(bt2), .instr_count(cnt2),
        .state_dbg(st2)
    );

    assign pc_m  = sel ? pc2  : pc1;
    assign fr_m  = sel ? fr2  : fr1;
    assign bt_m  = sel ? bt2  : bt1;
    assign cnt_m = sel ? cnt2 : cnt1;

    typedef struct {
        logic        rst;
        logic        br, bnz, ub, z;
        logic [63:0] se;
        int          stall_f, stall_e;
        logic [63:0] exp_pc;
        logic [31:0] exp_cnt;
        logic        exp_tk;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic scramble();
        Branch       = 1'($urandom_range(0, 1));
        BranchNZ     = 1'($urandom_range(0, 1));
        UncondBranch = 1'($urandom_range(0, 1));
        Zero         = 1'($urandom_range(0, 1));
        SEout        = {$urandom, $urandom};
    endtask

    task automatic clear_inputs();
        Branch = 0; BranchNZ = 0; UncondBranch = 0; Zero = 0;
        SEout = 0; exec_valid = 0; imem_ready = 0;
    endtask

    // Ends just after an edge with the selected DUT in FETCH.
    task automatic do_reset();
        logic [63:0] rpc;
        rpc = sel ? WRAP_PC : 64'h0;
        clear_inputs();
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_pc", pc_m, rpc);
        chk("reset_fetch_req", {63'd0, fr_m}, 64'd0);
        chk("reset_branch_taken", {63'd0, bt_m}, 64'd0);
        chk("reset_count", {32'd0, cnt_m}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("idle_fetch_req", {63'd0, fr_m}, 64'd0);
        step();
        chk("first_fetch_req", {63'd0, fr_m}, 64'd1);
        chk("first_fetch_pc", pc_m, rpc);
        m_pc  = rpc;
        m_cnt = 32'd0;
    endtask

    // One instruction from FETCH back to FETCH, with stalls and junk inputs
    // in the cycles where they must be ignored.
    task automatic run_instr(input logic br, input logic bnz, input logic ub,
                             input logic z, input logic [63:0] se,
                             input int stall_f, input int stall_e,
                             input logic [63:0] exp_next, input logic exp_tk);
        int fetch_cycles;
        fetch_cycles = 0;
        for (int i = 0; i <= stall_f; i++) begin
            if (fr_m) fetch_cycles++;
            chk("fetch_pc_hold", pc_m, m_pc);
            chk("fetch_no_pulse", {63'd0, bt_m}, 64'd0);
            scramble();
            exec_valid = 1'($urandom_range(0, 1));
            imem_ready = (i == stall_f);
            step();
        end
        chk("fetch_req_cycles", 64'(fetch_cycles), 64'(stall_f + 1));
        for (int i = 0; i <= stall_e; i++) begin
            chk("exec_fetch_req", {63'd0, fr_m}, 64'd0);
            chk("exec_pc_hold", pc_m, m_pc);
            chk("exec_no_pulse", {63'd0, bt_m}, 64'd0);
            imem_ready = 1'($urandom_range(0, 1));
            if (i == stall_e) begin
                Branch = br; BranchNZ = bnz; UncondBranch = ub; Zero = z; SEout = se;
                exec_valid = 1'b1;
            end else begin
                scramble();
                exec_valid = 1'b0;
            end
            step();
        end
        chk("update_pulse", {63'd0, bt_m}, {63'd0, exp_tk});
        chk("update_pc_hold", pc_m, m_pc);
        chk("update_count_hold", {32'd0, cnt_m}, {32'd0, m_cnt});
        chk("update_fetch_req", {63'd0, fr_m}, 64'd0);
        scramble();
        exec_valid = 1'($urandom_range(0, 1));
        imem_ready = 1'($urandom_range(0, 1));
        step();
        m_pc  = exp_next;
        m_cnt = m_cnt + 32'd1;
        chk("next_pc", pc_m, m_pc);
        chk("next_count", {32'd0, cnt_m}, {32'd0, m_cnt});
        chk("next_no_pulse", {63'd0, bt_m}, 64'd0);
        chk("next_fetch_req", {63'd0, fr_m}, 64'd1);
        imem_ready = 1'b0;
    endtask

    initial begin
        logic        rb, rbnz, rub, rz, rtk;
        logic [63:0] rse, rnext;
        logic signed [63:0] soff;
        int          rsf, rse_st;

        //            rst br bnz ub z  se                      sf se  exp_pc  cnt tk
        tbl[0]  = '{1'b1, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd4,  1, 0};
        tbl[1]  = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd8,  2, 0};
        tbl[2]  = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd12, 3, 0};
        tbl[3]  = '{1'b1, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd4,  1, 0};
        tbl[4]  = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd8,  2, 0};
        tbl[5]  = '{1'b0, 1, 0, 0, 0, 64'd5,                  0, 0, 64'd12, 3, 0};
        tbl[6]  = '{1'b1, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd4,  1, 0};
        tbl[7]  = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd8,  2, 0};
        tbl[8]  = '{1'b0, 1, 0, 0, 1, 64'd5,                  0, 0, 64'd28, 3, 1};
        tbl[9]  = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd32, 4, 0};
        tbl[10] = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd36, 5, 0};
        tbl[11] = '{1'b0, 0, 0, 0, 0, 64'd0,                  0, 0, 64'd40, 6, 0};
        tbl[12] = '{1'b0, 0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'd32, 7, 1};
        tbl[13] = '{1'b0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 64'd36, 8, 0};
        tbl[14] = '{1'b0, 0, 0, 0, 0, 64'd0,                  4, 2, 64'd40, 9, 0};
        tbl[15] = '{1'b0, 0, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFF6, 1, 1, 64'd0,  10, 1};
        tbl[16] = '{1'b0, 1, 1, 0, 1, 64'd3,                  0, 0, 64'd12, 11, 1};
        tbl[17] = '{1'b0, 1, 0, 0, 0, 64'd7,                  2, 0, 64'd16, 12, 0};

        sel = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) do_reset();
            run_instr(tbl[i].br, tbl[i].bnz, tbl[i].ub, tbl[i].z, tbl[i].se,
                      tbl[i].stall_f, tbl[i].stall_e, tbl[i].exp_pc, tbl[i].exp_tk);
            chk("table_count", {32'd0, cnt_m}, {32'd0, tbl[i].exp_cnt});
        end

        // Async reset while EXEC holds a taken branch not yet sampled.
        do_reset();
        run_instr(0, 0, 0, 0, 64'd0, 0, 0, 64'd4, 0);
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        UncondBranch = 1'b1; SEout = 64'd100; exec_valid = 1'b0;
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("midexec_reset_pc", pc_m, 64'd0);
        chk("midexec_reset_fetch_req", {63'd0, fr_m}, 64'd0);
        chk("midexec_reset_pulse", {63'd0, bt_m}, 64'd0);
        chk("midexec_reset_count", {32'd0, cnt_m}, 64'd0);
        do_reset();
        run_instr(0, 0, 0, 0, 64'd0, 0, 0, 64'd4, 0);

        // Async reset in UPDATE with a taken branch committed.
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        UncondBranch = 1'b1; SEout = 64'd100; exec_valid = 1'b1;
        step();
        chk("pending_pulse", {63'd0, bt_m}, 64'd1);
        clear_inputs();
        #3;
        reset = 1'b1;
        #1;
        chk("midupdate_reset_pulse", {63'd0, bt_m}, 64'd0);
        chk("midupdate_reset_pc", pc_m, 64'd0);
        do_reset();
        run_instr(0, 0, 0, 0, 64'd0, 0, 0, 64'd4, 0);

        // Random instructions against the instruction-level model.
        for (int i = 0; i < 40; i++) begin
            rb   = ($urandom_range(0, 3) == 0);
            rbnz = ($urandom_range(0, 3) == 0);
            rub  = ($urandom_range(0, 4) == 0);
            rz   = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) begin
                rse = {$urandom, $urandom};
            end else begin
                soff = 64'($urandom_range(0, 2000));
                soff = soff - 64'sd1000;
                rse  = soff;
            end
            rsf    = $urandom_range(0, 3);
            rse_st = $urandom_range(0, 3);
            rtk    = rub | (rb & rz) | (rbnz & !rz);
            rnext  = rtk ? m_pc + rse * 64'd4 : m_pc + 64'd4;
            run_instr(rb, rbnz, rub, rz, rse, rsf, rse_st, rnext, rtk);
        end

        // PC and counter wrap on the high-RESET_PC instance.
        sel = 1'b1;
        do_reset();
        run_instr(0, 0, 0, 0, 64'd0, 0, 0, 64'd0, 0);
        force dut2.instr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut2.instr_count_q;
        m_cnt = 32'hFFFF_FFFF;
        run_instr(0, 0, 0, 0, 64'd0, 1, 0, 64'd4, 0);
        chk("count_wrapped", {32'd0, cnt_m}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_branch_sequencer.md
PC_BRANCH_SEQUENCER -- requirements
Module: pc_branch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, giving the PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Branch  input  1  CBZ: branch if the ALU Zero flag is 1.
REQ-005 SHALL have port BranchNZ  input  1  CBNZ: branch if the ALU Zero flag is 0.
REQ-006 SHALL have port UncondBranch  input  1  B: branch always.
REQ-007 SHALL have port Zero  input  1  Zero flag from the RF/ALU stage.
REQ-008 SHALL have port SEout  input  64  sign-extended branch offset in words.
REQ-009 SHALL have port exec_valid  input  1  RF/ALU result and Zero are valid this cycle.
REQ-010 SHALL have port imem_ready  input  1  instruction memory has accepted the fetch at PC.
REQ-011 SHALL have port PC  output  64  current program counter.
REQ-012 SHALL have port fetch_req  output  1  request instruction at PC.
REQ-013 SHALL have port branch_taken  output  1  one-cycle pulse: a taken branch was committed.
REQ-014 SHALL have port instr_count  output  32  retired-instruction counter.

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, EXEC, UPDATE; encoding is free.
REQ-016 IDLE SHALL last exactly one cycle, then go to FETCH.
REQ-017 FETCH SHALL drive fetch_req=1.
- Stay in FETCH while imem_ready=0.
- Go to EXEC on the edge where imem_ready=1.
- fetch_req SHALL be 0 in every other state.
REQ-018 EXEC SHALL wait while exec_valid=0.
- On the edge where exec_valid=1, register taken and target, then go to UPDATE.
REQ-019 taken SHALL equal UncondBranch | (Branch & Zero) | (BranchNZ & ~Zero), sampled together with exec_valid.
- Multiple asserted branch controls SHALL OR together; there is no error state.
REQ-020 target SHALL equal PC + (SEout << 2), computed modulo 2^64; a negative SEout yields a backward branch.
REQ-021 UPDATE SHALL last one cycle and then return to FETCH.
- PC <= taken ? target : PC + 4, modulo 2^64.
- instr_count increments by 1 and wraps from 32'hFFFFFFFF to 0.
REQ-022 branch_taken SHALL be 1 only in the cycle the FSM is in UPDATE with taken=1, otherwise 0.
REQ-023 PC SHALL change only on the UPDATE->FETCH edge or on reset.
REQ-024 Inputs other than imem_ready in FETCH and exec_valid/branch inputs in EXEC SHALL be ignored.
- exec_valid asserted in FETCH SHALL have no effect.
REQ-025 Latency SHALL be a minimum of 3 cycles per instruction (FETCH, EXEC, UPDATE) when imem_ready and exec_valid are both 1 on first sample.

Reset
REQ-026 reset=1 SHALL, without waiting for clock, force the following, from any state including mid-FETCH or mid-EXEC:
- state=IDLE, PC=RESET_PC, instr_count=0, fetch_req=0, branch_taken=0, registered taken=0.
REQ-027 A branch decision pending in EXEC or UPDATE when reset asserts SHALL be discarded.
REQ-028 After reset deasserts, the first rising edge SHALL leave IDLE, and fetch_req SHALL rise one cycle later.

Verification
REQ-029 Sequential: reset, imem_ready=1, exec_valid=1, all branch inputs 0, run 3 instructions -> PC 0->4->8->12, instr_count=3, branch_taken never 1.
REQ-030 CBZ taken: PC=8, Branch=1, Zero=1, SEout=5 -> PC=28, one-cycle branch_taken pulse; with Zero=0 -> PC=12, no pulse.
REQ-031 CBNZ backward: PC=40, BranchNZ=1, Zero=0, SEout=64'hFFFF_FFFF_FFFF_FFFE -> PC=32.
REQ-032 Handshake stalls: imem_ready low 4 cycles, then exec_valid low 2 cycles -> fetch_req high 5 cycles, PC unchanged until UPDATE, instr_count +1 only once.
REQ-033 Wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, sequential -> PC=0; force instr_count to 32'hFFFFFFFF -> 0 after next UPDATE.
REQ-034 Async reset mid-EXEC with taken branch pending: assert reset between clock edges -> PC=RESET_PC and fetch_req=0 immediately, no branch_taken pulse, restart at RESET_PC.
